// File: rtl/palette_lookup.sv
// Palette lookup: converts a 9-bit palette index stream into 12-bit RGB pixels.
// CPU palette writes are held back until blanking; the RAM is cleared after reset.
module palette_lookup #(
  parameter int COLOR_W    = 12,
  parameter int DEPTH      = 512,
  parameter bit WR_ANYTIME = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_in,
  input  logic [8:0]         index_in,
  output logic               de_out,
  output logic [COLOR_W-1:0] rgb_out,
  input  logic               wr_req,
  input  logic [8:0]         wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_busy,
  output logic               wr_ack,
  output logic               init_done
);

  localparam int AW = 9;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_PENDING
  } state_t;

  state_t               state_reg;
  logic [AW-1:0]        clr_cnt_reg;
  logic [AW-1:0]        lat_addr_reg;
  logic [COLOR_W-1:0]   lat_data_reg;

  logic                 accept;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [COLOR_W-1:0]   mem_wdata;

  logic [COLOR_W-1:0]   mem [DEPTH];
  logic [COLOR_W-1:0]   ram_q_reg;
  logic                 de_s1_reg;

  // wr_busy stays high through the ack cycle, so a held wr_req is taken at most every 2 cycles.
  assign accept = (state_reg == S_IDLE) && wr_req && !wr_busy;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_reg;
    mem_wdata = '0;
    case (state_reg)
      S_INIT: begin
        mem_we = 1'b1;
      end
      S_IDLE: begin
        if (accept && (WR_ANYTIME || !de_in)) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = wr_data;
        end
      end
      S_PENDING: begin
        if (!de_in) begin
          mem_we    = 1'b1;
          mem_waddr = lat_addr_reg;
          mem_wdata = lat_data_reg;
        end
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_INIT;
      clr_cnt_reg  <= '0;
      lat_addr_reg <= '0;
      lat_data_reg <= '0;
      wr_busy      <= 1'b1;
      wr_ack       <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      case (state_reg)
        S_INIT: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == AW'(DEPTH - 1)) begin
            state_reg <= S_IDLE;
            init_done <= 1'b1;
            wr_busy   <= 1'b0;
          end
        end
        S_IDLE: begin
          if (wr_busy) begin
            wr_busy <= 1'b0;
          end else if (wr_req) begin
            lat_addr_reg <= wr_addr;
            lat_data_reg <= wr_data;
            wr_busy      <= 1'b1;
            if (WR_ANYTIME || !de_in) begin
              wr_ack <= 1'b1;
            end else begin
              state_reg <= S_PENDING;
            end
          end
        end
        S_PENDING: begin
          if (!de_in) begin
            wr_ack    <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_INIT;
        end
      endcase
    end
  end

  // Read-before-write: a same-address commit and read return the old entry.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    ram_q_reg <= mem[index_in];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1_reg <= 1'b0;
      de_out    <= 1'b0;
      rgb_out   <= '0;
    end else begin
      de_s1_reg <= de_in;
      de_out    <= de_s1_reg;
      rgb_out   <= (de_s1_reg && init_done) ? ram_q_reg : '0;
    end
  end

endmodule

// File: tb/tb_palette_lookup.sv
// Randomised self-checking bench for palette_lookup against a palette-array reference model.
module tb_palette_lookup;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_in, wr_req;
  logic [8:0]  index_in, wr_addr;
  logic [11:0] wr_data;
  logic        de_out, wr_busy, wr_ack, init_done;
  logic [11:0] rgb_out;

  logic        a_de_in, a_wr_req;
  logic [8:0]  a_index_in, a_wr_addr;
  logic [11:0] a_wr_data;
  logic        a_de_out, a_wr_busy, a_wr_ack, a_init_done;
  logic [11:0] a_rgb_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] pal [512];
  logic [8:0]  pix_idx [600];
  logic        pix_de  [600];
  logic [11:0] got_rgb [600];
  logic        got_de  [600];

  always #5 clk = ~clk;

  palette_lookup dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .index_in(index_in),
    .de_out(de_out), .rgb_out(rgb_out), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_busy(wr_busy), .wr_ack(wr_ack), .init_done(init_done)
  );

  palette_lookup #(.WR_ANYTIME(1'b1)) dut_any (
    .clk(clk), .rst_n(rst_n), .de_in(a_de_in), .index_in(a_index_in),
    .de_out(a_de_out), .rgb_out(a_rgb_out), .wr_req(a_wr_req), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_busy(a_wr_busy), .wr_ack(a_wr_ack), .init_done(a_init_done)
  );

  // Drives pix_idx/pix_de one per cycle and captures outputs 2 cycles later.
  task automatic play(input int n);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        got_rgb[i-2] = rgb_out;
        got_de[i-2]  = de_out;
      end
      if (i < n) begin
        de_in    = pix_de[i];
        index_in = pix_idx[i];
      end else begin
        de_in = 1'b0;
      end
    end
  endtask

  task automatic drive_write(input logic [8:0] addr, input logic [11:0] data);
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    bit ack_seen;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (de_out !== 1'b0) begin n_bad++; $display("FAIL reset_de_out: got %b expected 0", de_out); end
    n_cmp++; if (rgb_out !== 12'h000) begin n_bad++; $display("FAIL reset_rgb: got %h expected 000", rgb_out); end
    n_cmp++; if (wr_busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b expected 1", wr_busy); end
    n_cmp++; if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", wr_ack); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    for (int i = 0; i < 512; i++) pal[i] = 12'h000;
    // A request held during INIT must be neither latched nor acknowledged.
    wr_req = 1'b1; wr_addr = 9'h0AA; wr_data = 12'h5A5;
    rst_n = 1'b1;
    n = 0; ack_seen = 1'b0;
    while (n < 1000) begin
      @(posedge clk); n++; #1;
      if (wr_ack) ack_seen = 1'b1;
      if (n == 100) wr_req = 1'b0;
      if (init_done) break;
    end
    n_cmp++; if (n !== 512) begin n_bad++; $display("FAIL init_cycles: got %0d expected 512", n); end
    n_cmp++; if (wr_busy !== 1'b0) begin n_bad++; $display("FAIL init_busy_fall: got %b expected 0", wr_busy); end
    n_cmp++; if (ack_seen !== 1'b0) begin n_bad++; $display("FAIL init_ack: got %b expected 0", ack_seen); end
    n_cmp++; if (a_init_done !== 1'b1) begin n_bad++; $display("FAIL any_init_done: got %b expected 1", a_init_done); end
    $display("reset: init_done after %0d cycles", n);
  endtask

  task automatic test_init_clear;
    for (int i = 0; i < 512; i++) begin pix_idx[i] = 9'(i); pix_de[i] = 1'b1; end
    play(512);
    for (int i = 0; i < 512; i++) begin
      n_cmp++;
      if (got_rgb[i] !== 12'h000 || got_de[i] !== 1'b1) begin
        n_bad++; $display("FAIL init_clear[%0d]: got rgb=%h de=%b expected rgb=000 de=1", i, got_rgb[i], got_de[i]);
      end
    end
    $display("init_clear: 512 indices read back");
  endtask

  task automatic test_basic_write;
    de_in = 1'b0;
    drive_write(9'h007, 12'h3A5);
    pal[7] = 12'h3A5;
    n_cmp++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL basic_ack: got %b expected 1", wr_ack); end
    @(negedge clk);
    n_cmp++; if (wr_ack !== 1'b0 || wr_busy !== 1'b0) begin n_bad++; $display("FAIL basic_after_ack: got ack=%b busy=%b expected 0 0", wr_ack, wr_busy); end
    pix_idx[0] = 9'h007; pix_de[0] = 1'b1;
    play(1);
    n_cmp++;
    if (got_rgb[0] !== pal[7] || got_de[0] !== 1'b1) begin
      n_bad++; $display("FAIL basic_read: got rgb=%h de=%b expected rgb=%h de=1", got_rgb[0], got_de[0], pal[7]);
    end
    $display("basic_write: addr 007 <= 3A5, read %h", got_rgb[0]);
  endtask

  task automatic test_pending;
    de_in = 1'b1; index_in = 9'h010;
    drive_write(9'h010, 12'hFFF);
    n_cmp++; if (wr_busy !== 1'b1 || wr_ack !== 1'b0) begin n_bad++; $display("FAIL pend_busy: got busy=%b ack=%b expected 1 0", wr_busy, wr_ack); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wr_req = (k < 2); wr_addr = 9'h011; wr_data = 12'h123;
      n_cmp++;
      if (wr_ack !== 1'b0 || wr_busy !== 1'b1 || rgb_out !== pal[9'h010]) begin
        n_bad++; $display("FAIL pend_hold[%0d]: got ack=%b busy=%b rgb=%h expected 0 1 %h", k, wr_ack, wr_busy, rgb_out, pal[9'h010]);
      end
    end
    wr_req = 1'b0;
    @(negedge clk);
    de_in = 1'b0;
    @(negedge clk);
    pal[9'h010] = 12'hFFF;
    n_cmp++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL pend_ack: got %b expected 1", wr_ack); end
    @(negedge clk);
    n_cmp++; if (wr_ack !== 1'b0 || wr_busy !== 1'b0) begin n_bad++; $display("FAIL pend_release: got ack=%b busy=%b expected 0 0", wr_ack, wr_busy); end
    pix_idx[0] = 9'h010; pix_de[0] = 1'b1;
    pix_idx[1] = 9'h011; pix_de[1] = 1'b1;
    play(2);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (got_rgb[i] !== pal[pix_idx[i]]) begin
        n_bad++; $display("FAIL pend_read[%0d]: got %h expected %h", i, got_rgb[i], pal[pix_idx[i]]);
      end
    end
    $display("pending: deferred write committed, 010=%h 011=%h", got_rgb[0], got_rgb[1]);
  endtask

  task automatic test_hold_req;
    logic [11:0] d [6];
    de_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (wr_ack !== ((i - 1) % 2 == 0)) begin
          n_bad++; $display("FAIL hold_ack[%0d]: got %b expected %b", i - 1, wr_ack, ((i - 1) % 2 == 0));
        end
      end
      if (i < 6) begin
        d[i] = 12'($urandom);
        wr_req = 1'b1; wr_addr = 9'h100 + 9'(i); wr_data = d[i];
        if (i % 2 == 0) pal[9'h100 + 9'(i)] = d[i];
      end else begin
        wr_req = 1'b0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin pix_idx[i] = 9'h100 + 9'(i); pix_de[i] = 1'b1; end
    play(6);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (got_rgb[i] !== pal[pix_idx[i]]) begin
        n_bad++; $display("FAIL hold_read[%0d]: got %h expected %h", i, got_rgb[i], pal[pix_idx[i]]);
      end
    end
    $display("hold_req: 6 cycles of wr_req, 3 writes expected");
  endtask

  task automatic test_palette0_stream;
    de_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_write(9'(i), 12'(i * 12'h111));
      pal[i] = 12'(i * 12'h111);
      n_cmp++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL p0_ack[%0d]: got %b expected 1", i, wr_ack); end
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin pix_idx[i] = 9'(i); pix_de[i] = (i != 5); end
    play(16);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (got_rgb[i] !== (pix_de[i] ? pal[i] : 12'h000) || got_de[i] !== pix_de[i]) begin
        n_bad++; $display("FAIL p0_stream[%0d]: got rgb=%h de=%b expected rgb=%h de=%b", i, got_rgb[i], got_de[i], pix_de[i] ? pal[i] : 12'h000, pix_de[i]);
      end
    end
    $display("palette0_stream: 16 pixels, pixel 5 blanked");
  endtask

  task automatic test_random;
    logic [8:0]  a;
    logic [11:0] v;
    de_in = 1'b0;
    for (int k = 0; k < 24; k++) begin
      a = 9'($urandom_range(0, 511));
      v = 12'($urandom);
      drive_write(a, v);
      pal[a] = v;
      n_cmp++; if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL rand_ack[%0d]: got %b expected 1", k, wr_ack); end
    end
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      pix_idx[i] = 9'($urandom_range(0, 511));
      pix_de[i]  = ($urandom_range(0, 4) != 0);
    end
    play(200);
    for (int i = 0; i < 200; i++) begin
      n_cmp++;
      if (got_rgb[i] !== (pix_de[i] ? pal[pix_idx[i]] : 12'h000) || got_de[i] !== pix_de[i]) begin
        n_bad++; $display("FAIL rand_pixel[%0d]: idx=%h got rgb=%h de=%b expected rgb=%h de=%b", i, pix_idx[i], got_rgb[i], got_de[i], pix_de[i] ? pal[pix_idx[i]] : 12'h000, pix_de[i]);
      end
    end
    $display("random: 24 writes, 200 pixels");
  endtask

  task automatic test_anytime;
    @(negedge clk);
    a_de_in = 1'b0; a_wr_req = 1'b1; a_wr_addr = 9'h020; a_wr_data = 12'h111;
    @(negedge clk);
    a_wr_req = 1'b0;
    n_cmp++; if (a_wr_ack !== 1'b1) begin n_bad++; $display("FAIL any_ack0: got %b expected 1", a_wr_ack); end
    @(negedge clk);
    a_de_in = 1'b1; a_index_in = 9'h020; a_wr_req = 1'b1; a_wr_data = 12'h222;
    @(negedge clk);
    a_wr_req = 1'b0;
    n_cmp++; if (a_wr_ack !== 1'b1) begin n_bad++; $display("FAIL any_ack_visible: got %b expected 1", a_wr_ack); end
    @(negedge clk);
    a_de_in = 1'b0;
    n_cmp++; if (a_rgb_out !== 12'h111) begin n_bad++; $display("FAIL any_collide_old: got %h expected 111", a_rgb_out); end
    @(negedge clk);
    n_cmp++; if (a_rgb_out !== 12'h222 || a_de_out !== 1'b1) begin n_bad++; $display("FAIL any_next_new: got rgb=%h de=%b expected 222 1", a_rgb_out, a_de_out); end
    $display("anytime: collision old=111 then new=222");
  endtask

  task automatic test_reset_mid;
    int n;
    bit ack_seen;
    de_in = 1'b1; index_in = 9'h000;
    drive_write(9'h1F0, 12'hABC);
    n_cmp++; if (wr_busy !== 1'b1) begin n_bad++; $display("FAIL rst_pend_busy: got %b expected 1", wr_busy); end
    #2 rst_n = 1'b0;
    de_in = 1'b0;
    #1;
    n_cmp++;
    if (de_out !== 1'b0 || rgb_out !== 12'h000 || wr_busy !== 1'b1 || wr_ack !== 1'b0 || init_done !== 1'b0) begin
      n_bad++; $display("FAIL rst_pend_vals: got de=%b rgb=%h busy=%b ack=%b done=%b expected 0 000 1 0 0", de_out, rgb_out, wr_busy, wr_ack, init_done);
    end
    for (int i = 0; i < 512; i++) pal[i] = 12'h000;
    ack_seen = 1'b0;
    repeat (2) begin @(negedge clk); if (wr_ack) ack_seen = 1'b1; end
    rst_n = 1'b1;
    n = 0;
    while (n < 300) begin @(posedge clk); n++; #1; if (wr_ack) ack_seen = 1'b1; end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init300_done: got %b expected 0", init_done); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (wr_busy !== 1'b1 || init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init300_vals: got busy=%b done=%b expected 1 0", wr_busy, init_done); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(posedge clk); n++; #1;
      if (wr_ack) ack_seen = 1'b1;
      if (init_done) break;
    end
    n_cmp++; if (n !== 512) begin n_bad++; $display("FAIL rst_reinit_cycles: got %0d expected 512", n); end
    n_cmp++; if (ack_seen !== 1'b0) begin n_bad++; $display("FAIL rst_dropped_ack: got %b expected 0", ack_seen); end
    pix_idx[0] = 9'h1F0; pix_de[0] = 1'b1;
    pix_idx[1] = 9'h007; pix_de[1] = 1'b1;
    pix_idx[2] = 9'h00F; pix_de[2] = 1'b1;
    play(3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got_rgb[i] !== pal[pix_idx[i]]) begin
        n_bad++; $display("FAIL rst_cleared[%0d]: got %h expected %h", i, got_rgb[i], pal[pix_idx[i]]);
      end
    end
    $display("reset_mid: re-init took %0d cycles", n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    de_in = 1'b0; index_in = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    a_de_in = 1'b0; a_index_in = '0; a_wr_req = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    test_reset();
    test_init_clear();
    test_basic_write();
    test_pending();
    test_hold_req();
    test_palette0_stream();
    test_random();
    test_anytime();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
